// File: rtl/cache_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_bank_ctrl
//  Description : Two-requester front end for a dual-port cache bank with a
//                per-line written bitmap and a conflict stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 6
`endif
`ifndef CACHE_BANK_LINES
`define CACHE_BANK_LINES (2**`CACHE_BANK_ADDRESS_WIDTH)
`endif

module cache_bank_ctrl #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `CACHE_BANK_ADDRESS_WIDTH,
  parameter int LINES      = `CACHE_BANK_LINES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,

  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_hit,

  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_hit,

  output logic [ADDR_WIDTH-1:0] bank_addr_A,
  output logic [DATA_WIDTH-1:0] bank_dataIn_A,
  output logic                  bank_wen_A,
  input  logic [DATA_WIDTH-1:0] bank_dataOut_A,

  output logic [ADDR_WIDTH-1:0] bank_addr_B,
  output logic [DATA_WIDTH-1:0] bank_dataIn_B,
  output logic                  bank_wen_B,
  input  logic [DATA_WIDTH-1:0] bank_dataOut_B,

  output logic [15:0]           conflict_count
);

  logic [LINES-1:0] r_written;
  logic             r_rsp0Valid;
  logic             r_rsp0Hit;
  logic             r_rsp1Valid;
  logic             r_rsp1Hit;
  logic [15:0]      r_conflictCount;

  logic             w_conflict;
  logic             w_acc0;
  logic             w_acc1;

  // A write on either side of a same-line pair stalls requester 1; read/read may share.
  assign w_conflict = req0_valid & req1_valid & (req0_addr == req1_addr) &
                      (req0_write | req1_write);

  assign req0_ready = ~reset & ~flush;
  assign req1_ready = ~reset & ~flush & ~w_conflict;

  assign w_acc0 = req0_valid & req0_ready;
  assign w_acc1 = req1_valid & req1_ready;

  assign bank_addr_A   = w_acc0 ? req0_addr  : '0;
  assign bank_dataIn_A = w_acc0 ? req0_wdata : '0;
  assign bank_wen_A    = w_acc0 ? ~req0_write : 1'b1;

  assign bank_addr_B   = w_acc1 ? req1_addr  : '0;
  assign bank_dataIn_B = w_acc1 ? req1_wdata : '0;
  assign bank_wen_B    = w_acc1 ? ~req1_write : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_written       <= '0;
      r_rsp0Valid     <= 1'b0;
      r_rsp0Hit       <= 1'b0;
      r_rsp1Valid     <= 1'b0;
      r_rsp1Hit       <= 1'b0;
      r_conflictCount <= '0;
    end else begin
      // Hit reflects the bitmap before this edge's update, so flush cannot touch it.
      r_rsp0Valid <= w_acc0 & ~req0_write;
      r_rsp0Hit   <= w_acc0 & ~req0_write & r_written[req0_addr];
      r_rsp1Valid <= w_acc1 & ~req1_write;
      r_rsp1Hit   <= w_acc1 & ~req1_write & r_written[req1_addr];

      if (flush) begin
        r_written <= '0;
      end else begin
        if (w_acc0 & req0_write) r_written[req0_addr] <= 1'b1;
        if (w_acc1 & req1_write) r_written[req1_addr] <= 1'b1;
      end

      if (w_conflict & ~flush & (r_conflictCount != 16'hFFFF))
        r_conflictCount <= r_conflictCount + 16'd1;
    end
  end

  assign rsp0_valid     = r_rsp0Valid;
  assign rsp0_hit       = r_rsp0Hit;
  assign rsp0_data      = bank_dataOut_A;
  assign rsp1_valid     = r_rsp1Valid;
  assign rsp1_hit       = r_rsp1Hit;
  assign rsp1_data      = bank_dataOut_B;
  assign conflict_count = r_conflictCount;

endmodule

`default_nettype wire
